// File: rtl/dm_port_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arb_if
// Purpose  : CPU / loader request ports plus the shared data-memory port.
// Revision : 1.0  initial release
// ============================================================================
interface dm_port_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          lock1;
    logic          gnt1;
    logic          rvalid1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    // Requesters and the memory sit on the master side.
    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1, lock1,
        input  gnt1, rvalid1, rdata1,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1, lock1,
        output gnt1, rvalid1, rdata1,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/dm_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : dm_port_arb
// Purpose  : Round-robin CPU/loader arbiter and sequencer for the data memory.
// Revision : 1.0  initial release
// ============================================================================
module dm_port_arb #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_f,
    dm_port_arb_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [2:0] c_LAT_LOAD = 3'(RD_LAT - 1);

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic          r_lock_hold;
    logic          r_win;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_mem_we;
    logic          r_busy;

    logic          w_any;
    logic          w_pick1;

    always_comb begin
        w_any   = bus.req0 | bus.req1;
        w_pick1 = 1'b0;
        if (r_lock_hold && bus.req1)
            w_pick1 = 1'b1;
        else if (bus.req1 && !bus.req0)
            w_pick1 = 1'b1;
        else if (bus.req0 && !bus.req1)
            w_pick1 = 1'b0;
        else
            w_pick1 = ~r_last;
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 3'd0;
            r_last      <= 1'b1;
            r_lock_hold <= 1'b0;
            r_win       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_we  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        // Grant, strobe and round-robin state all take effect in the issue cycle.
                        r_win       <= w_pick1;
                        r_we        <= w_pick1 ? bus.we1    : bus.we0;
                        r_addr      <= w_pick1 ? bus.addr1  : bus.addr0;
                        r_wdata     <= w_pick1 ? bus.wdata1 : bus.wdata0;
                        r_mem_we    <= w_pick1 ? bus.we1    : bus.we0;
                        r_gnt0      <= ~w_pick1;
                        r_gnt1      <= w_pick1;
                        r_last      <= w_pick1;
                        r_lock_hold <= w_pick1 & bus.lock1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_ISSUE;
                    end else begin
                        r_lock_hold <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                c_ST_ISSUE: begin
                    if (r_we) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt   <= c_LAT_LOAD;
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_win) begin
                            r_rdata1  <= bus.mem_rdata;
                            r_rvalid1 <= 1'b1;
                        end else begin
                            r_rdata0  <= bus.mem_rdata;
                            r_rvalid0 <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.rvalid0   = r_rvalid0;
    assign bus.rvalid1   = r_rvalid1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_dm_port_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arb
// Purpose  : Scoreboard bench for dm_port_arb with a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_port_arb;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    typedef struct {
        int            cyc;
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        int            cyc;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;

    logic clk   = 1'b0;
    logic rst_f = 1'b1;

    dm_port_arb_if #(.AW(AW), .DW(DW)) bus ();

    dm_port_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    gnt_t gq[$];
    rd_t  rq[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   busy_lo = -1;
    int   busy_hi = -1;
    bit   mon_en  = 1'b0;
    bit   auto0   = 1'b0;
    bit   auto1   = 1'b0;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {a ^ 16'h5AC3, ~a};
    endfunction

    // Memory: returns data RD_LAT cycles after a read issue, junk otherwise.
    logic [AW-1:0] pa [RD_LAT];
    logic          pv [RD_LAT];
    always @(posedge clk) begin
        pa[0] <= bus.mem_addr;
        pv[0] <= (bus.gnt0 | bus.gnt1) & ~bus.mem_we;
        for (int i = 1; i < RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.mem_rdata = pv[RD_LAT-1] ? mem_f(pa[RD_LAT-1]) : (32'hBAD0_0000 | 32'(cyc));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic agent_step();
        if (bus.gnt0) bus.req0 = 1'b0;
        else if (auto0 && !bus.req0 && $urandom_range(0, 2) == 0) begin
            bus.we0    = 1'($urandom_range(0, 1));
            bus.addr0  = AW'($urandom);
            bus.wdata0 = $urandom;
            bus.req0   = 1'b1;
        end
        if (bus.gnt1) bus.req1 = 1'b0;
        else if (auto1 && !bus.req1 && $urandom_range(0, 2) == 0) begin
            bus.we1    = 1'($urandom_range(0, 1));
            bus.addr1  = AW'($urandom);
            bus.wdata1 = $urandom;
            bus.lock1  = ($urandom_range(0, 3) != 0);
            bus.req1   = 1'b1;
        end
    endtask

    task automatic serve(input int lim);
        int k;
        k = 0;
        while ((bus.req0 || bus.req1) && k < lim) begin
            tick();
            agent_step();
            k++;
        end
        chk("req_served", 64'(bus.req0 | bus.req1), 64'd0);
    endtask

    // Reference model: decides winners from sampled requests and the arbitration rules.
    initial begin : predictor
        bit            m_last;
        bit            m_lock;
        bit            w;
        bit            we;
        int            free_edge;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        m_last    = 1'b1;
        m_lock    = 1'b0;
        free_edge = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst_f) begin
                gq.delete();
                rq.delete();
                m_last    = 1'b1;
                m_lock    = 1'b0;
                free_edge = cyc + 1;
                busy_lo   = -1;
                busy_hi   = -1;
            end else if (cyc >= free_edge) begin
                if (bus.req0 || bus.req1) begin
                    if (m_lock && bus.req1)        w = 1'b1;
                    else if (bus.req0 != bus.req1) w = bus.req1;
                    else                           w = ~m_last;
                    we = w ? bus.we1    : bus.we0;
                    a  = w ? bus.addr1  : bus.addr0;
                    d  = w ? bus.wdata1 : bus.wdata0;
                    gq.push_back('{cyc, w, we, a, d});
                    if (!we) rq.push_back('{cyc + RD_LAT + 1, w, mem_f(a)});
                    busy_lo   = cyc;
                    busy_hi   = we ? cyc : cyc + RD_LAT;
                    free_edge = we ? cyc + 2 : cyc + RD_LAT + 2;
                    m_last    = w;
                    m_lock    = w & bus.lock1;
                end else begin
                    m_lock = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        gnt_t g;
        rd_t  r;
        bit   eg;
        bit   er;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                eg = 1'b0;
                er = 1'b0;
                g.cyc = 0; g.port = 1'b0; g.we = 1'b0; g.addr = '0; g.wdata = '0;
                r.cyc = 0; r.port = 1'b0; r.data = '0;
                if (gq.size() != 0 && gq[0].cyc <= cyc) begin
                    g  = gq.pop_front();
                    eg = 1'b1;
                end
                if (rq.size() != 0 && rq[0].cyc <= cyc) begin
                    r  = rq.pop_front();
                    er = 1'b1;
                end
                chk("gnt0",   64'(bus.gnt0),   64'(eg & ~g.port));
                chk("gnt1",   64'(bus.gnt1),   64'(eg & g.port));
                chk("mem_we", 64'(bus.mem_we), 64'(eg & g.we));
                if (eg) begin
                    chk("mem_addr",  64'(bus.mem_addr),  64'(g.addr));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
                end
                chk("rvalid0", 64'(bus.rvalid0), 64'(er & ~r.port));
                chk("rvalid1", 64'(bus.rvalid1), 64'(er & r.port));
                if (er) chk(r.port ? "rdata1" : "rdata0",
                            64'(r.port ? bus.rdata1 : bus.rdata0), 64'(r.data));
                chk("busy", 64'(bus.busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            end
        end
    end

    initial begin : stimulus
        int         k;
        int         n1;
        logic [4:0] seq;
        int         gc [4];
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.lock1 = 1'b0;
        for (int i = 0; i < 4; i++) gc[i] = 0;

        tick();
        mon_en = 1'b1;
        tick();
        rst_f = 1'b0;
        repeat (10) tick();
        chk("rst_rdata0",   64'(bus.rdata0),   64'd0);
        chk("rst_rdata1",   64'(bus.rdata1),   64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);

        // Single CPU write, then a CPU read.
        bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 32'hDEADBEEF; bus.req0 = 1'b1;
        serve(20);
        repeat (3) tick();
        bus.we0 = 1'b0; bus.addr0 = 16'h0042; bus.req0 = 1'b1;
        serve(20);
        repeat (5) tick();

        // Both ports held high: strict alternation, one grant every two cycles.
        bus.we0 = 1'b1; bus.addr0 = 16'h0020; bus.wdata0 = 32'h0000_0A0A;
        bus.we1 = 1'b1; bus.addr1 = 16'h0030; bus.wdata1 = 32'h0000_0B0B; bus.lock1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        k = 0; n1 = 0; seq = '0;
        while (n1 < 4 && k < 40) begin
            tick(); k++;
            if (bus.gnt0 | bus.gnt1) begin
                seq = {seq[3:0], bus.gnt1};
                gc[n1] = cyc;
                n1++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("contend_order", 64'(seq[3:0]), 64'(4'b1010));
        chk("contend_span",  64'(gc[3] - gc[0]), 64'd6);
        repeat (4) tick();

        // Loader burst lock against a waiting CPU.
        bus.we1 = 1'b1; bus.addr1 = 16'h0100; bus.wdata1 = 32'hA5A5_0001; bus.lock1 = 1'b1;
        bus.we0 = 1'b1; bus.addr0 = 16'h0200; bus.wdata0 = 32'h5A5A_0002;
        bus.req1 = 1'b1;
        k = 0; n1 = 0; seq = '0;
        while (n1 < 5 && k < 60) begin
            tick(); k++;
            if (bus.gnt0 | bus.gnt1) begin
                seq = {seq[3:0], bus.gnt1};
                n1++;
                if (n1 == 1) bus.req0 = 1'b1;
                if (n1 == 2) bus.lock1 = 1'b0;
                if (bus.gnt0) bus.req0 = 1'b0;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("lock_order", 64'(seq), 64'(5'b11101));
        repeat (4) tick();

        // Reset while a CPU read waits on memory.
        bus.we0 = 1'b0; bus.addr0 = 16'h0077; bus.req0 = 1'b1;
        k = 0;
        while (!bus.gnt0 && k < 20) begin
            tick(); k++;
        end
        bus.req0 = 1'b0;
        chk("abort_gnt", 64'(bus.gnt0), 64'd1);
        tick();
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        chk("abort_busy",    64'(bus.busy),    64'd0);
        chk("abort_rvalid0", 64'(bus.rvalid0), 64'd0);
        bus.addr0 = 16'h0078; bus.req0 = 1'b1;
        serve(20);
        repeat (5) tick();

        // Randomized traffic with occasional resets.
        auto0 = 1'b1; auto1 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            agent_step();
            if ($urandom_range(0, 599) == 0) begin
                rst_f = 1'b1;
                tick();
                rst_f = 1'b0;
            end
        end
        auto0 = 1'b0; auto1 = 1'b0;
        k = 0;
        while ((bus.req0 || bus.req1 || gq.size() != 0 || rq.size() != 0 || cyc <= busy_hi) && k < 200) begin
            tick();
            agent_step();
            k++;
        end
        chk("drain_queues", 64'(gq.size() + rq.size()), 64'd0);
        chk("drain_req",    64'(bus.req0 | bus.req1),   64'd0);
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dm_port_arb.md
Name: dm_port_arb

Overview:
Two-port arbiter and sequencer for the SISC data memory. It shares the single data-memory port between the CPU memory stage (port 0) and the program/debug loader (port 1). Accepted requests are captured, issued to memory as a single-cycle access, and completed with a write acknowledge or a read-data return after a fixed memory latency. Ties are resolved round-robin, and the loader can lock consecutive grants for bursts.

Parameters:
AW, 16, address width.
DW, 32, data width.
RD_LAT, 1, data-memory read latency in cycles measured from the issue cycle; legal range 1..7.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_f  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
req0  input  1  CPU request; held until gnt0.
we0  input  1  CPU write enable; 1 = write, 0 = read.
addr0  input  AW  CPU address.
wdata0  input  DW  CPU write data.
gnt0  output  1  one-cycle pulse: CPU request issued to memory.
rvalid0  output  1  one-cycle pulse: rdata0 valid.
rdata0  output  DW  CPU read data.
req1, we1, addr1, wdata1  input  1/1/AW/DW  loader request; same rules as port 0.
lock1  input  1  loader burst lock; sampled with req1.
gnt1, rvalid1, rdata1  output  1/1/DW  loader grant, read-valid and read data.
mem_addr  output  AW  to data memory.
mem_wdata  output  DW  to data memory.
mem_we  output  1  to data memory; one-cycle write strobe.
mem_rdata  input  DW  from data memory.
busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (rst_f=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: gnt*, rvalid*, rdata*, mem_*, busy.
  - Priority pointer last=1, so port 0 wins the first tie.
  - Latency counter cleared; any lock cleared.
- Reset mid-transaction aborts the transaction. No gnt, rvalid or mem_we may pulse on the cycle after reset. An aborted request is not replayed; the requester must re-request.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is high, select a winner and capture its we, addr and wdata into registers, then go to ISSUE.
  - Winner selection:
    - Locked burst: if lock_hold=1 and req1=1, port 1 wins.
    - Else if only one req is high, that port wins.
    - Else the port != last wins.
  - If no req is high, stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_addr and mem_wdata come from the captured registers; mem_we = captured we.
  - gnt of the winner = 1. last is updated to the winner.
  - lock_hold = (winner==1) & lock1 captured in IDLE.
  - Write: next state IDLE.
  - Read: load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - mem_we=0; mem_addr is held.
  - When the counter reaches 0, register mem_rdata into the winner's rdata, pulse the winner's rvalid in the following cycle, and return to IDLE.
  - rvalid coincides with the first IDLE cycle after WAIT.
  - rdata holds its value until the next read completes on that port.
- Latency from the first IDLE cycle with req sampled:
  - Write: gnt 1 cycle later.
  - Read: rvalid RD_LAT+2 cycles later.
- Throughput limits: back-to-back writes take 2 cycles each; reads take RD_LAT+2 cycles each.
- Requester rules:
  - A request is committed when captured in IDLE. Dropping req afterwards does not cancel it.
  - The requester must deassert req in the cycle after gnt. If req is still high in the next IDLE it is treated as a new request.
- Simultaneous req0 and req1 with no lock: requests alternate strictly. Neither port waits more than one transaction.
- Lock limits and tie rule:
  - lock1 can starve port 0 only while req1 stays continuously asserted. When lock1=0 or req1=0 is sampled in IDLE, lock_hold clears.
  - lock0 does not exist; the CPU is never locked.
- Request arriving during ISSUE or WAIT: not sampled until IDLE; held req are honoured then.
- Address and data are passed through unmodified; no width conversion. Upper address bits beyond the memory size are the memory's concern.
- Only one transaction is in flight at a time; there is no pipelining of issue and WAIT.

Test Plan:
- Reset then idle: rst_f=1 for 2 cycles, then 0, no req → all outputs 0 and busy=0 for 10 cycles.
- Single CPU write: req0=1, we0=1, addr0=16'h0010, wdata0=32'hDEADBEEF → next cycle mem_we=1 with mem_addr=0010, mem_wdata=DEADBEEF, and gnt0=1 for one cycle. gnt1 stays 0.
- CPU read, RD_LAT=1: memory model returns 32'h12345678 → gnt0 at t+1, rvalid0 at t+3 with rdata0=12345678, busy high for exactly 2 cycles.
- Contention: req0 and req1 held high, both writes, lock1=0 → grants alternate gnt0, gnt1, gnt0, gnt1, each 2 cycles apart.
- Loader lock: req1=1, lock1=1 for 3 writes while req0=1 → three consecutive gnt1, then gnt0 on the first IDLE after lock1 drops.
- Reset mid-read: reset asserted in WAIT → no rvalid0; busy=0 the next cycle; a new req0 completes normally.
